// File: rtl/piano_pkg.sv
// Shared definitions for the piano game: state encoding, slot and key geometry,
// LFSR tap mask and a small popcount helper.
package piano_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_WIN  = 2'd2,
    ST_LOSE = 2'd3
  } state_e;

  localparam int NSLOT   = 3;
  localparam int KEY_W   = 4;
  localparam int SCORE_W = 11;

  // Taps 16,14,13,11 map onto bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; shifts left with the tap parity fed into bit 0.
module lfsr16
  import piano_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] q
);

  logic [15:0] q_d;
  logic [15:0] q_q;

  always_comb begin
    q_d = {q_q[14:0], ^(q_q & LFSR_TAPS)};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/note_scheduler.sv
// Game sequencer for the three falling-block slots: launches blocks, assigns
// random target keys, keeps score and lives, ramps speed and decides win/lose.
module note_scheduler
  import piano_pkg::*;
#(
  parameter int          WIN_SCORE = 100,
  parameter int          LIVES     = 3,
  parameter int          GAP_BASE  = 60,
  parameter int          GAP_MIN   = 12,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   frame_tick,
  input  logic [NSLOT-1:0]       hit,
  input  logic [NSLOT-1:0]       miss,
  output logic [NSLOT-1:0]       slot_ena,
  output logic [KEY_W-1:0]       target0,
  output logic [KEY_W-1:0]       target1,
  output logic [KEY_W-1:0]       target2,
  output logic [2:0]             slow,
  output logic [SCORE_W-1:0]     score,
  output logic [1:0]             lives,
  output logic                   win,
  output logic                   lose,
  output logic                   playing
);

  state_e                         state_q, state_d;
  logic [NSLOT-1:0]               slot_ena_q, slot_ena_d;
  logic [NSLOT-1:0][KEY_W-1:0]    tgt_q, tgt_d;
  logic [2:0]                     slow_q, slow_d;
  logic [SCORE_W-1:0]             score_q, score_d;
  logic [1:0]                     lives_q, lives_d;
  logic [7:0]                     gap_cnt_q, gap_cnt_d;

  logic [15:0]                    lfsr_s;
  logic [11:0]                    lfsr_unused_s;
  logic [9:0]                     gap_step_s;
  logic [7:0]                     gap_s;
  logic [NSLOT-1:0]               hit_s, loss_s, free_s;
  logic [SCORE_W:0]               score_sum_s;
  logic [1:0]                     loss_cnt_s;

  lfsr16 #(.SEED(SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_s)
  );

  assign lfsr_unused_s = lfsr_s[15:4];

  // Launch spacing shrinks by 6 frames per speed level, floored at GAP_MIN.
  always_comb begin
    gap_step_s = 10'(slow_q) * 10'd6;
    if (10'(GAP_BASE) < gap_step_s + 10'(GAP_MIN)) begin
      gap_s = 8'(GAP_MIN);
    end else begin
      gap_s = 8'(10'(GAP_BASE) - gap_step_s);
    end
  end

  // Next-state, launch and accounting logic.
  always_comb begin
    state_d     = state_q;
    slot_ena_d  = slot_ena_q;
    tgt_d       = tgt_q;
    score_d     = score_q;
    lives_d     = lives_q;
    gap_cnt_d   = gap_cnt_q;
    slow_d      = (score_q[10:4] > 7'd7) ? 3'd7 : score_q[6:4];
    hit_s       = hit & slot_ena_q;
    loss_s      = miss & ~hit & slot_ena_q;
    free_s      = ~slot_ena_q;
    score_sum_s = {1'b0, score_q} + {10'd0, popcount3(hit_s)};
    loss_cnt_s  = popcount3(loss_s);

    case (state_q)
      ST_PLAY: begin
        if (lives_q == 2'd0) begin
          state_d    = ST_LOSE;
          slot_ena_d = 3'b000;
        end else if (score_q >= 11'(WIN_SCORE)) begin
          state_d    = ST_WIN;
          slot_ena_d = 3'b000;
        end else begin
          // Freed slots only become launchable from the next cycle on.
          slot_ena_d = slot_ena_q & ~(hit | miss);
          score_d    = score_sum_s[SCORE_W] ? 11'h7FF : score_sum_s[SCORE_W-1:0];
          lives_d    = (lives_q > loss_cnt_s) ? (lives_q - loss_cnt_s) : 2'd0;
          if ((gap_cnt_q >= gap_s) && (free_s != 3'b000)) begin
            gap_cnt_d = 8'd0;
            if (free_s[0]) begin
              slot_ena_d[0] = 1'b1;
              tgt_d[0]      = lfsr_s[3:0];
            end else if (free_s[1]) begin
              slot_ena_d[1] = 1'b1;
              tgt_d[1]      = lfsr_s[3:0];
            end else begin
              slot_ena_d[2] = 1'b1;
              tgt_d[2]      = lfsr_s[3:0];
            end
          end else if (frame_tick && (gap_cnt_q != 8'hFF)) begin
            gap_cnt_d = gap_cnt_q + 8'd1;
          end else begin
            gap_cnt_d = gap_cnt_q;
          end
        end
      end
      ST_IDLE, ST_WIN, ST_LOSE: begin
        if (start) begin
          state_d    = ST_PLAY;
          slot_ena_d = 3'b000;
          score_d    = 11'd0;
          lives_d    = 2'(LIVES);
          gap_cnt_d  = 8'd0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        slot_ena_d = 3'b000;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      slot_ena_q <= 3'b000;
      tgt_q      <= '{default: 4'd0};
      slow_q     <= 3'd0;
      score_q    <= 11'd0;
      lives_q    <= 2'(LIVES);
      gap_cnt_q  <= 8'd0;
    end else begin
      state_q    <= state_d;
      slot_ena_q <= slot_ena_d;
      tgt_q      <= tgt_d;
      slow_q     <= slow_d;
      score_q    <= score_d;
      lives_q    <= lives_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign slot_ena = slot_ena_q;
  assign target0  = tgt_q[0];
  assign target1  = tgt_q[1];
  assign target2  = tgt_q[2];
  assign slow     = slow_q;
  assign score    = score_q;
  assign lives    = lives_q;
  assign win      = (state_q == ST_WIN);
  assign lose     = (state_q == ST_LOSE);
  assign playing  = (state_q == ST_PLAY);

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler with a reference LFSR and an expected-value queue.
module tb_note_scheduler;

  localparam logic [15:0] SEED_C = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        frame_tick = 1'b0;
  logic [2:0]  hit = 3'b000;
  logic [2:0]  miss = 3'b000;
  logic [2:0]  slot_ena;
  logic [3:0]  target0, target1, target2;
  logic [2:0]  slow;
  logic [10:0] score;
  logic [1:0]  lives;
  logic        win, lose, playing;

  int checks = 0;
  int errors = 0;
  int exp_score = 0;
  int exp_lives = 3;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_t;
  sb_t sb_q[$];

  logic [15:0] lfsr_m;
  logic [15:0] lfsr_pre;

  note_scheduler #(
    .WIN_SCORE (100),
    .LIVES     (3),
    .GAP_BASE  (60),
    .GAP_MIN   (12),
    .SEED      (16'hACE1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .frame_tick (frame_tick),
    .hit        (hit),
    .miss       (miss),
    .slot_ena   (slot_ena),
    .target0    (target0),
    .target1    (target1),
    .target2    (target2),
    .slow       (slow),
    .score      (score),
    .lives      (lives),
    .win        (win),
    .lose       (lose),
    .playing    (playing)
  );

  always #20 clk = ~clk;

  // Reference Fibonacci LFSR, taps 16,14,13,11.
  always @(posedge clk) begin
    if (!rst) lfsr_m <= SEED_C;
    else      lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  initial begin
    #50000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  task automatic expect_next(input string tag, input logic [31:0] e);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sb_q.push_back(s);
  endtask

  task automatic check_out(input logic [31:0] obs);
    sb_t s;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %0h with nothing expected", obs);
    end else begin
      s = sb_q.pop_front();
      assert (obs === s.exp) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", s.tag, obs, s.exp);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    expect_next(tag, e);
    check_out(obs);
  endtask

  task automatic step();
    lfsr_pre = lfsr_m;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cycle(input logic st, input logic ft, input logic [2:0] h, input logic [2:0] m);
    start = st; frame_tick = ft; hit = h; miss = m;
    step();
    start = 1'b0; frame_tick = 1'b0; hit = 3'b000; miss = 3'b000;
  endtask

  function automatic int low_free(input logic [2:0] v);
    if (!v[0])      return 0;
    else if (!v[1]) return 1;
    else            return 2;
  endfunction

  function automatic logic [3:0] target_of(input int i);
    case (i)
      0:       return target0;
      1:       return target1;
      default: return target2;
    endcase
  endfunction

  // Tick frames until every slot is busy, checking each launch as it happens.
  task automatic fill_slots();
    logic [2:0] prev;
    int n;
    int i;
    n = 0;
    while (slot_ena !== 3'b111 && n < 2000) begin
      prev = slot_ena;
      drive_cycle(1'b0, 1'b1, 3'b000, 3'b000);
      n++;
      if (slot_ena !== prev) begin
        i = low_free(prev);
        chk("launch_slot", slot_ena, prev | (3'b001 << i));
        chk("launch_target", target_of(i), lfsr_pre[3:0]);
      end
    end
    if (n >= 2000) chk("fill_timeout", slot_ena, 3'b111);
  endtask

  task automatic hit_round(input logic [2:0] h, input logic [2:0] m, input int dscore, input int dlives);
    fill_slots();
    exp_score += dscore;
    exp_lives -= dlives;
    expect_next("round_score", exp_score);
    expect_next("round_lives", exp_lives);
    drive_cycle(1'b0, 1'b0, h, m);
    check_out(score);
    check_out(lives);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) step();
    chk("rst_slot_ena", slot_ena, 3'b000);
    chk("rst_target0", target0, 4'd0);
    chk("rst_target1", target1, 4'd0);
    chk("rst_target2", target2, 4'd0);
    chk("rst_slow", slow, 3'd0);
    chk("rst_score", score, 11'd0);
    chk("rst_lives", lives, 2'd3);
    chk("rst_win", win, 1'b0);
    chk("rst_lose", lose, 1'b0);
    chk("rst_playing", playing, 1'b0);
    rst = 1'b1;
    step();
    chk("idle_playing", playing, 1'b0);

    drive_cycle(1'b1, 1'b0, 3'b000, 3'b000);
    chk("start_playing", playing, 1'b1);
    chk("start_score", score, 11'd0);

    // Gap counter reaches 60 on the 60th tick; launch lands on the following edge.
    repeat (60) drive_cycle(1'b0, 1'b1, 3'b000, 3'b000);
    chk("gap60_not_yet", slot_ena, 3'b000);
    drive_cycle(1'b0, 1'b0, 3'b000, 3'b000);
    chk("launch0", slot_ena, 3'b001);
    chk("launch0_target", target0, lfsr_pre[3:0]);
    repeat (60) drive_cycle(1'b0, 1'b1, 3'b000, 3'b000);
    chk("gap60_second_not_yet", slot_ena, 3'b001);
    drive_cycle(1'b0, 1'b0, 3'b000, 3'b000);
    chk("launch1", slot_ena, 3'b011);
    chk("launch1_target", target1, lfsr_pre[3:0]);
    repeat (61) drive_cycle(1'b0, 1'b1, 3'b000, 3'b000);
    chk("launch2", slot_ena, 3'b111);
    chk("launch2_target", target2, lfsr_pre[3:0]);

    repeat (200) drive_cycle(1'b0, 1'b1, 3'b000, 3'b000);
    chk("all_busy_no_launch", slot_ena, 3'b111);
    drive_cycle(1'b0, 1'b0, 3'b000, 3'b010);
    chk("miss1_clears", slot_ena, 3'b101);
    chk("miss1_lives", lives, 2'd2);
    drive_cycle(1'b0, 1'b0, 3'b000, 3'b000);
    chk("slot1_relaunch", slot_ena, 3'b111);
    chk("slot1_relaunch_target", target1, lfsr_pre[3:0]);

    exp_lives = 2;
    exp_score = 3;
    expect_next("hit_all_score", exp_score);
    drive_cycle(1'b0, 1'b0, 3'b111, 3'b000);
    check_out(score);
    chk("hit_all_frees", slot_ena, 3'b000);
    expect_next("hit_idle_ignored", exp_score);
    drive_cycle(1'b0, 1'b0, 3'b001, 3'b000);
    check_out(score);

    hit_round(3'b100, 3'b100, 1, 0);
    chk("hit_miss_same_slot_frees", slot_ena, 3'b011);

    for (int r = 0; r < 4; r++) hit_round(3'b111, 3'b000, 3, 0);
    chk("slow_lags_score", slow, 3'd0);
    drive_cycle(1'b0, 1'b0, 3'b000, 3'b000);
    chk("slow_level1", slow, 3'd1);
    repeat (54) drive_cycle(1'b0, 1'b1, 3'b000, 3'b000);
    chk("gap54_not_yet", slot_ena, 3'b000);
    drive_cycle(1'b0, 1'b0, 3'b000, 3'b000);
    chk("gap54_launch", slot_ena, 3'b001);

    for (int r = 0; r < 28; r++) hit_round(3'b111, 3'b000, 3, 0);
    drive_cycle(1'b0, 1'b0, 3'b000, 3'b000);
    chk("win_flag", win, 1'b1);
    chk("win_not_playing", playing, 1'b0);
    chk("win_slots_off", slot_ena, 3'b000);
    chk("win_slow", slow, 3'd6);
    drive_cycle(1'b0, 1'b1, 3'b111, 3'b000);
    chk("win_score_frozen", score, 11'd100);

    drive_cycle(1'b1, 1'b0, 3'b000, 3'b000);
    chk("restart_playing", playing, 1'b1);
    chk("restart_win_low", win, 1'b0);
    chk("restart_score", score, 11'd0);
    chk("restart_lives", lives, 2'd3);
    exp_score = 0;
    exp_lives = 3;

    hit_round(3'b000, 3'b011, 0, 2);
    for (int r = 0; r < 33; r++) hit_round(3'b111, 3'b000, 3, 0);
    hit_round(3'b001, 3'b010, 1, 1);
    drive_cycle(1'b0, 1'b0, 3'b000, 3'b000);
    chk("lose_priority", lose, 1'b1);
    chk("lose_not_win", win, 1'b0);
    chk("lose_slots_off", slot_ena, 3'b000);

    drive_cycle(1'b1, 1'b0, 3'b000, 3'b000);
    exp_score = 0;
    exp_lives = 3;
    hit_round(3'b111, 3'b000, 3, 0);
    repeat (70) drive_cycle(1'b0, 1'b1, 3'b000, 3'b000);
    rst = 1'b0;
    step();
    chk("midrst_slot_ena", slot_ena, 3'b000);
    chk("midrst_target0", target0, 4'd0);
    chk("midrst_target1", target1, 4'd0);
    chk("midrst_target2", target2, 4'd0);
    chk("midrst_score", score, 11'd0);
    chk("midrst_lives", lives, 2'd3);
    chk("midrst_slow", slow, 3'd0);
    chk("midrst_playing", playing, 1'b0);
    chk("midrst_win", win, 1'b0);
    chk("midrst_lose", lose, 1'b0);
    rst = 1'b1;
    drive_cycle(1'b0, 1'b1, 3'b000, 3'b000);
    chk("after_rst_idle", playing, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Sequences the three falling-block slots of the piano game.
- Decides when each slot launches and which key it targets, tallies hits and misses into score and lives, ramps the fall speed, and declares win or lose.
- Sits between the top-level mode logic and the three block_move instances.
- Drives their enable, target and speed inputs; consumes their hit/miss pulses.

Parameters:
- NSLOT, 3, number of block slots (the logic below is written for 3).
- WIN_SCORE, 100, score at which the game is won (11-bit value).
- LIVES, 3, misses allowed before losing (1..3).
- GAP_BASE, 60, frames between launches at speed level 0.
- GAP_MIN, 12, floor on frames between launches.
- SEED, 16'hACE1, LFSR reset seed; must be nonzero.

Ports:
- clk  in  1  25 MHz pixel clock.
- rst  in  1  synchronous reset, active-low.
- start  in  1  one-cycle pulse; begins a new game from IDLE, WIN or LOSE.
- frame_tick  in  1  one-cycle pulse per VGA frame.
- hit  in  3  per-slot pulse: correct key pressed on the block.
- miss  in  3  per-slot pulse: wrong key, or block left the screen.
- slot_ena  out  3  per-slot run enable to block_move.
- target0, target1, target2  out  4 each  key index assigned to the slot.
- slow  out  3  speed level 0..7.
- score  out  11  current score.
- lives  out  2  remaining lives.
- win  out  1  high while in WIN.
- lose  out  1  high while in LOSE.
- playing  out  1  high while in PLAY.

Behaviour:
Reset (rst=0 at a clk edge):
- state=IDLE; slot_ena=0; targets=0; slow=0; score=0; lives=LIVES; win=lose=playing=0; gap counter=0; LFSR=SEED.

States:
- IDLE: outputs quiescent. start -> PLAY.
- PLAY: playing=1.
- WIN: win=1, slot_ena=0, score frozen. start -> PLAY.
- LOSE: lose=1, slot_ena=0, score frozen. start -> PLAY.
- Entering PLAY from any state clears score, gap counter and slot_ena and reloads lives=LIVES. The LFSR is not reseeded.

LFSR:
- 16-bit Fibonacci, taps 16,14,13,11.
- Advances every clk in every state, so target sequences differ from game to game.

Launch, in PLAY:
- The gap counter increments on frame_tick, saturating at 255.
- When gap counter >= gap and at least one slot is free, the lowest-index free slot i launches:
  - slot_ena[i]<=1;
  - target_i<=LFSR[3:0] on that same edge;
  - gap counter<=0.
- gap = max(GAP_MIN, GAP_BASE - 6*slow).
- At most one launch per clk.
- If all slots are busy, the counter keeps saturating and the launch fires on the first free cycle.

Completion:
- hit[i] or miss[i] is honoured only when slot_ena[i]=1; pulses on idle slots are ignored.
- A completing slot clears slot_ena[i] on the next edge. It is eligible to launch again one cycle later; no launch into a slot in the same cycle it is freed.
- Per cycle, score += popcount(hit & slot_ena), saturating at 2047.
- If hit[i] and miss[i] are both asserted, hit wins and no life is lost.
- lives -= popcount(miss & ~hit & slot_ena), saturating at 0.

Speed:
- slow = min(score[10:4], 7), registered.
- slow updates one cycle after score.

Terminal conditions, evaluated on the registered score and lives:
- lives==0 -> LOSE.
- else score >= WIN_SCORE -> WIN.
- If both hold in the same cycle, LOSE has priority.
- On entry to either terminal state, all slot_ena are cleared on the same edge.

Other rules:
- start while in PLAY is ignored.
- Reset mid-game returns everything to the reset values above; no pulses are retained.

Decomposition:
- Shared package piano_pkg holds:
  - state encoding (IDLE=0, PLAY=1, WIN=2, LOSE=3);
  - NSLOT;
  - key index width (4);
  - score width (11);
  - LFSR tap constant.
- One sub-module, lfsr16 (clk, rst, q[15:0]), free-running with a seed parameter.
- Launch and accounting stay in note_scheduler.

Test Plan:
- Reset, then start, then 60 frame_ticks -> slot_ena=3'b001 and target0 equals LFSR[3:0] at the launch edge; 60 more ticks -> 3'b011.
- All three slots busy and 200 ticks -> no launch; miss[1] pulse -> slot_ena[1] clears, lives=2, slot 1 relaunches two cycles later.
- hit=3'b111 with all slots busy -> score +3 in one cycle; hit[0] with slot 0 idle -> score unchanged.
- hit[2] and miss[2] together on a busy slot -> score +1, lives unchanged.
- Drive score to 16 -> slow=1 one cycle later and gap becomes 54; at score 100 -> WIN, win=1, slot_ena=0; start -> PLAY with score=0, lives=3.
- lives=1, score=99, and in one cycle hit[0] plus miss[1] -> LOSE (not WIN); rst=0 mid-PLAY -> IDLE with all outputs at reset values.
